// File: rtl/fetch_queue.sv
// IF-to-ID fetch FIFO holding {pc, instr, misaligned} entries so a one-cycle ID stall
// does not immediately back-pressure the PC register; flush empties it on a redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_adel,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic             adel_q  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, wr_en;

  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_en     = push & ~flush;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    // A redirect discards everything, including an entry arriving this cycle.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Empty head reads as a nop at PC 0 so ID never sees stale storage.
  assign out_pc    = out_valid ? pc_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_adel  = out_valid ? adel_q[rd_ptr_q]  : 1'b0;
  assign count     = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        adel_q[i]  <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (wr_en) begin
        pc_q[wr_ptr_q]    <= in_pc;
        instr_q[wr_ptr_q] <= in_instr;
        adel_q[wr_ptr_q]  <= |in_pc[1:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver queues expected head entries as it pushes,
// and a negedge monitor checks status outputs and every popped head against that queue.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_adel;
  logic             out_ready;
  logic             flush;
  logic [PTR_W:0]   count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  ent_t exp_q[$];
  ent_t e;
  int   mcount;
  int   n_checks;
  int   n_fail;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus, starting just after a rising edge; the model is updated at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl,
                      input logic exp_adel);
    logic mpush, mpop;
    ent_t ne;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {16'h2408, pc[15:0]};
    out_ready = ordy;
    flush     = fl;
    mpush = v && (mcount != DEPTH) && !fl;
    mpop  = ordy && (mcount != 0) && !fl;
    ne.pc    = pc;
    ne.instr = {16'h2408, pc[15:0]};
    ne.adel  = exp_adel;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (mpush) exp_q.push_back(ne);
      mcount = mcount + int'(mpush) - int'(mpop);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: status every cycle, head contents whenever the DUT hands an entry to ID.
  initial begin
    forever begin
      @(negedge clk);
      chk("count", 32'(count), 32'(mcount));
      chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      if (mcount == 0) begin
        chk("empty_out_pc", out_pc, 32'h0);
        chk("empty_out_instr", out_instr, 32'h0);
        chk("empty_out_adel", 32'(out_adel), 32'h0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h expected no entry at %0t", out_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", out_pc, e.pc);
          chk("head_instr", out_instr, e.instr);
          chk("head_adel", 32'(out_adel), 32'(e.adel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    mcount    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Fill to full, then a fifth push must be refused.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3010, 1'b0, 1'b0, 1'b0);
    idle();

    // Drain in order.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Streaming push+pop for 10 cycles, pointers wrap twice.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Flush at count 3 with a concurrent push, then a fresh push reaches the head.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3020, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h4000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Misaligned PC flags only its own entry.
    step(1'b1, 32'h3002, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Asynchronous reset between edges at count 2.
    step(1'b1, 32'h5000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5004, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd2);
    #1 reset = 1'b0;
    exp_q.delete();
    mcount = 0;
    #1;
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_in_ready", 32'(in_ready), 32'd1);
    chk("async_reset_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle();

    // Normal operation resumes after reset.
    step(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover_entries: got %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
